// File: rtl/rpsc_pkg.sv
// rpsc_pkg: shared types and enable-order constants for the RPSC sequencer
package rpsc_pkg;
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    UP_CA = 4'd1,
    UP_G1 = 4'd2,
    UP_G2 = 4'd3,
    UP_AN = 4'd4,
    UP_DR = 4'd5,
    RUN   = 4'd6,
    DOWN  = 4'd7,
    FAULT = 4'd8
  } seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_EMERG = 2'd1,
    FC_OVC   = 2'd2,
    FC_MISM  = 2'd3
  } fault_code_t;

  // Bit positions in the enable vector; UP_x encodes as EN_x + 1 so the
  // state value leaving UP_x is the index of the next enable to set.
  localparam int EN_CA = 0;
  localparam int EN_G1 = 1;
  localparam int EN_G2 = 2;
  localparam int EN_AN = 3;
  localparam int EN_DR = 4;
  localparam int EN_RF = 5;
endpackage

// File: rtl/rpsc_tune_delay.sv
// rpsc_tune_delay: saturating qualifier that drops not_tune_ok once tune-OK is stable
module rpsc_tune_delay #(
  parameter int TUNE_DELAY = 5000,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_tune_ok,
  output logic o_not_tune_ok_delayed
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             full;

  // Count consecutive tune-OK cycles; output falls the edge after saturation
  always_comb begin
    full  = cnt_q == CNT_W'(TUNE_DELAY);
    cnt_d = !i_tune_ok ? '0 : full ? cnt_q : cnt_q + 1'b1;
    out_d = !(i_tune_ok && full);
  end

  // Register counter and output with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      out_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign o_not_tune_ok_delayed = out_q;
endmodule

// File: rtl/rpsc_seq_ctrl.sv
// rpsc_seq_ctrl: timed PS/RF enable sequencer with latched interlock trips
module rpsc_seq_ctrl
  import rpsc_pkg::*;
#(
  parameter int STEP_DELAY   = 1000,
  parameter int TUNE_DELAY   = 5000,
  parameter int ALARM_SETTLE = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_fault_reset,
  input  logic       i_tune_ok,
  input  logic       i_emergency,
  input  logic       i_i_an_high_n,
  input  logic       i_not_alarm,
  output logic       o_ca_ps_ctrl,
  output logic       o_g1_ps_ctrl,
  output logic       o_g2_ps_ctrl,
  output logic       o_anode_ps_ctrl,
  output logic       o_dr_amp_ctrl,
  output logic       o_rf_permit_ctrl,
  output logic       o_not_tune_ok_delayed,
  output logic       o_running,
  output logic       o_fault,
  output logic [1:0] o_fault_code,
  output logic [3:0] o_state
);
  seq_state_t       state_q, state_d;
  fault_code_t      code_q, code_d;
  logic [5:0]       en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, running_d, fault_q, fault_d;
  logic             step_done, settled, active, up, trip_em, trip_oc, trip_mm, stop_req;

  // Next-state: trips beat stop requests, which beat normal sequencing
  always_comb begin
    step_done = cnt_q == CNT_W'(STEP_DELAY - 1);
    settled   = cnt_q >= CNT_W'(ALARM_SETTLE);
    up        = state_q inside {UP_CA, UP_G1, UP_G2, UP_AN, UP_DR};
    active    = state_q != IDLE && state_q != FAULT;
    trip_em   = active && i_emergency;
    trip_oc   = active && !i_i_an_high_n && en_q[EN_AN];
    trip_mm   = state_q == RUN && settled && !i_not_alarm;
    stop_req  = (up || state_q == RUN) && (i_stop || !i_start);
    state_d   = state_q;
    code_d    = code_q;
    en_d      = en_q;
    cnt_d     = cnt_q;
    if (trip_em || trip_oc || trip_mm) begin
      state_d = FAULT;
      en_d    = '0;
      cnt_d   = '0;
      code_d  = trip_em ? FC_EMERG : trip_oc ? FC_OVC : FC_MISM;
    end else if (stop_req) begin
      state_d      = DOWN;
      en_d[EN_RF]  = 1'b0;
      cnt_d        = '0;
    end else begin
      case (state_q)
        IDLE: if (i_start && !i_stop) begin
          state_d     = UP_CA;
          en_d[EN_CA] = 1'b1;
          cnt_d       = '0;
        end
        UP_CA, UP_G1, UP_G2, UP_AN, UP_DR: if (step_done) begin
          state_d = seq_state_t'(state_q + 4'd1);
          en_d    = en_q | (6'd1 << state_q);
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
        RUN: cnt_d = settled ? cnt_q : cnt_q + 1'b1;
        DOWN: if (step_done) begin
          en_d    = en_q >> 1;
          state_d = en_q[5:1] == '0 ? IDLE : DOWN;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
        FAULT: if (i_fault_reset && !i_start && !i_emergency) begin
          state_d = IDLE;
          code_d  = FC_NONE;
        end
        default: begin
          state_d = IDLE;
          en_d    = '0;
          cnt_d   = '0;
        end
      endcase
    end
    running_d = state_d == RUN;
    fault_d   = state_d == FAULT;
  end

  // Sequencer state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      code_q    <= FC_NONE;
      en_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      en_q      <= en_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      fault_q   <= fault_d;
    end
  end

  rpsc_tune_delay #(.TUNE_DELAY(TUNE_DELAY), .CNT_W(CNT_W)) u_tune (
    .clk                   (clk),
    .reset_n               (reset_n),
    .i_tune_ok             (i_tune_ok),
    .o_not_tune_ok_delayed (o_not_tune_ok_delayed)
  );

  assign o_ca_ps_ctrl     = en_q[EN_CA];
  assign o_g1_ps_ctrl     = en_q[EN_G1];
  assign o_g2_ps_ctrl     = en_q[EN_G2];
  assign o_anode_ps_ctrl  = en_q[EN_AN];
  assign o_dr_amp_ctrl    = en_q[EN_DR];
  assign o_rf_permit_ctrl = en_q[EN_RF];
  assign o_running        = running_q;
  assign o_fault          = fault_q;
  assign o_fault_code     = code_q;
  assign o_state          = state_q;
endmodule

// File: tb/tb_rpsc_seq_ctrl.sv
// tb_rpsc_seq_ctrl: directed scoreboard bench for the RPSC sequencer
module tb_rpsc_seq_ctrl;
  logic       clk = 1'b0;
  logic       reset_n, start, stop, fr, tune, emerg, an_n, na;
  logic       ca, g1, g2, an, dr, rf, ntune, running, fault;
  logic [1:0] code;
  logic [3:0] st;
  int         edges = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int          cyc;
    string       nm;
    logic [14:0] v;
  } exp_t;
  exp_t q[$];

  rpsc_seq_ctrl #(.STEP_DELAY(4), .TUNE_DELAY(5), .ALARM_SETTLE(2), .CNT_W(16)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .i_start               (start),
    .i_stop                (stop),
    .i_fault_reset         (fr),
    .i_tune_ok             (tune),
    .i_emergency           (emerg),
    .i_i_an_high_n         (an_n),
    .i_not_alarm           (na),
    .o_ca_ps_ctrl          (ca),
    .o_g1_ps_ctrl          (g1),
    .o_g2_ps_ctrl          (g2),
    .o_anode_ps_ctrl       (an),
    .o_dr_amp_ctrl         (dr),
    .o_rf_permit_ctrl      (rf),
    .o_not_tune_ok_delayed (ntune),
    .o_running             (running),
    .o_fault               (fault),
    .o_fault_code          (code),
    .o_state               (st)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Queue an expectation k edges from now: enables {rf..ca}, state, code, not_tune_ok
  task automatic ex(input int k, input string nm, input logic [5:0] en, input logic [3:0] s,
                    input logic [1:0] c, input logic nt = 1'b1);
    exp_t e;
    int   i;
    e.cyc = edges + k;
    e.nm  = nm;
    e.v   = {en, nt, s == 4'd6, s == 4'd8, c, s};
    i = 0;
    while (i < q.size() && q[i].cyc <= e.cyc) i++;
    q.insert(i, e);
  endtask

  // Monitor: compare every expectation due at this cycle against DUT outputs
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= edges) begin
      exp_t        e;
      logic [14:0] act;
      e   = q.pop_front();
      act = {rf, dr, an, g2, g1, ca, ntune, running, fault, code, st};
      checks++;
      if (e.cyc != edges) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.nm, e.cyc, edges);
      end else if (act !== e.v) begin
        errors++;
        $display("FAIL %s @%0d: got en=%b nt=%b run=%b flt=%b code=%0d st=%0d, expected en=%b nt=%b run=%b flt=%b code=%0d st=%0d",
                 e.nm, edges, act[14:9], act[8], act[7], act[6], act[5:4], act[3:0],
                 e.v[14:9], e.v[8], e.v[7], e.v[6], e.v[5:4], e.v[3:0]);
      end
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; fr = 1'b0; tune = 1'b0;
    emerg = 1'b0; an_n = 1'b1; na = 1'b1;
    @(negedge clk);
    ex(1, "reset", 6'h00, 4'd0, 2'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // power-up
    start = 1'b1;
    ex(1, "up_ca", 6'h01, 4'd1, 2'd0);
    ex(4, "up_ca_hold", 6'h01, 4'd1, 2'd0);
    ex(5, "up_g1", 6'h03, 4'd2, 2'd0);
    ex(9, "up_g2", 6'h07, 4'd3, 2'd0);
    ex(13, "up_an", 6'h0f, 4'd4, 2'd0);
    ex(17, "up_dr", 6'h1f, 4'd5, 2'd0);
    ex(20, "up_dr_hold", 6'h1f, 4'd5, 2'd0);
    ex(21, "run", 6'h3f, 4'd6, 2'd0);
    repeat (21) @(negedge clk);
    // orderly stop
    stop = 1'b1; start = 1'b0;
    ex(1, "down_rf", 6'h1f, 4'd7, 2'd0);
    ex(4, "down_hold", 6'h1f, 4'd7, 2'd0);
    ex(5, "down_dr", 6'h0f, 4'd7, 2'd0);
    ex(9, "down_an", 6'h07, 4'd7, 2'd0);
    ex(13, "down_g2", 6'h03, 4'd7, 2'd0);
    ex(17, "down_g1", 6'h01, 4'd7, 2'd0);
    ex(21, "down_idle", 6'h00, 4'd0, 2'd0);
    @(negedge clk);
    stop = 1'b0;
    repeat (20) @(negedge clk);
    // overcurrent in UP_AN, simultaneous stop loses to the trip
    start = 1'b1;
    repeat (13) @(negedge clk);
    an_n = 1'b0; stop = 1'b1;
    ex(1, "ovc_trip", 6'h00, 4'd8, 2'd2);
    @(negedge clk);
    an_n = 1'b1; stop = 1'b0; fr = 1'b1;
    ex(1, "fr_with_start", 6'h00, 4'd8, 2'd2);
    @(negedge clk);
    start = 1'b0;
    ex(1, "ovc_clear", 6'h00, 4'd0, 2'd0);
    @(negedge clk);
    fr = 1'b0;
    // simultaneous emergency + mismatch in RUN
    start = 1'b1;
    ex(24, "run_settled", 6'h3f, 4'd6, 2'd0);
    repeat (24) @(negedge clk);
    emerg = 1'b1; na = 1'b0;
    ex(1, "emerg_prio", 6'h00, 4'd8, 2'd1);
    @(negedge clk);
    start = 1'b0; fr = 1'b1; na = 1'b1; an_n = 1'b0;
    ex(1, "emerg_hold", 6'h00, 4'd8, 2'd1);
    @(negedge clk);
    emerg = 1'b0; an_n = 1'b1;
    ex(1, "emerg_clear", 6'h00, 4'd0, 2'd0);
    @(negedge clk);
    fr = 1'b0;
    // mismatch settle window
    start = 1'b1;
    repeat (21) @(negedge clk);
    na = 1'b0;
    ex(1, "settle1", 6'h3f, 4'd6, 2'd0);
    ex(2, "settle2", 6'h3f, 4'd6, 2'd0);
    ex(3, "mismatch", 6'h00, 4'd8, 2'd3);
    repeat (3) @(negedge clk);
    na = 1'b1; start = 1'b0; fr = 1'b1;
    ex(1, "mism_clear", 6'h00, 4'd0, 2'd0);
    @(negedge clk);
    fr = 1'b0;
    // tune delay
    tune = 1'b1;
    ex(4, "tune_4", 6'h00, 4'd0, 2'd0, 1'b1);
    repeat (4) @(negedge clk);
    tune = 1'b0;
    ex(1, "tune_short", 6'h00, 4'd0, 2'd0, 1'b1);
    @(negedge clk);
    tune = 1'b1;
    ex(5, "tune_5", 6'h00, 4'd0, 2'd0, 1'b1);
    ex(6, "tune_ok", 6'h00, 4'd0, 2'd0, 1'b0);
    repeat (6) @(negedge clk);
    tune = 1'b0;
    ex(1, "tune_lost", 6'h00, 4'd0, 2'd0, 1'b1);
    @(negedge clk);
    // reset mid-sequence
    start = 1'b1; tune = 1'b1;
    ex(10, "mid_g2", 6'h07, 4'd3, 2'd0, 1'b0);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    ex(1, "mid_reset", 6'h00, 4'd0, 2'd0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1; start = 1'b0; tune = 1'b0;
    ex(1, "post_reset", 6'h00, 4'd0, 2'd0, 1'b1);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      errors += q.size();
      $display("FAIL drain: %0d expectations never checked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rpsc_seq_ctrl.md
Name: rpsc_seq_ctrl

Overview:
Power-supply sequencer for the RPSC chassis. It is the driving end of the interlock interface that the combinational interlock card reads. It generates the six PS/RF control enables in a timed order, generates Not_TUNE_OK_Delayed, and consumes the interlock card's Emergency, I_AN_HIGH (active-low) and Not_Alarm returns to trip and latch faults. It sits between the operator/front-panel logic and the interlock card.

Parameters:
STEP_DELAY, 1000, clk cycles between successive enable steps (power-up and power-down); minimum 1.
TUNE_DELAY, 5000, consecutive clk cycles i_tune_ok must be high before o_not_tune_ok_delayed deasserts; minimum 1.
ALARM_SETTLE, 16, clk cycles after entering RUN before an i_not_alarm mismatch is treated as a fault.
CNT_W, 16, width of the shared step/settle counter and of the tune counter; must hold max(STEP_DELAY, TUNE_DELAY, ALARM_SETTLE).

Ports:
clk  in  1  system clock; the only clock.
reset_n  in  1  synchronous reset, active-low.
i_start  in  1  level: request power-up / stay on.
i_stop  in  1  pulse or level: request orderly power-down.
i_fault_reset  in  1  clears a latched fault; honoured only when i_start=0.
i_tune_ok  in  1  raw cavity tune-OK.
i_emergency  in  1  Emergency return from the interlock card; 1 = trip.
i_i_an_high_n  in  1  I_AN_HIGH return; 0 = anode overcurrent.
i_not_alarm  in  1  Not_Alarm return (AND of all enables as seen by the interlock card).
o_ca_ps_ctrl  out  1  cathode PS enable.
o_g1_ps_ctrl  out  1  G1 PS enable.
o_g2_ps_ctrl  out  1  G2 PS enable.
o_anode_ps_ctrl  out  1  anode PS enable.
o_dr_amp_ctrl  out  1  driver amplifier enable.
o_rf_permit_ctrl  out  1  RF permit (TED).
o_not_tune_ok_delayed  out  1  0 once tune is OK and stable for TUNE_DELAY cycles.
o_running  out  1  1 in RUN.
o_fault  out  1  latched fault.
o_fault_code  out  2  0 none, 1 emergency, 2 overcurrent, 3 alarm mismatch.
o_state  out  4  current state encoding, for diagnostics.

Behaviour:
- All outputs are registered. On reset (reset_n=0 at a clk edge): state IDLE, all six enables 0, counters 0, o_not_tune_ok_delayed=1, o_running=0, o_fault=0, o_fault_code=0. Reset mid-sequence drops all enables on that edge.
- States: IDLE, UP_CA, UP_G1, UP_G2, UP_AN, UP_DR, RUN, DOWN, FAULT.
- IDLE: if i_start=1, i_stop=0 and no fault -> UP_CA. Entering UP_x sets that enable, and all earlier enables stay set. Each UP_x lasts STEP_DELAY cycles, then advances. Order: CA, G1, G2, AN, DR. The exit of UP_DR sets RF permit and enters RUN.
- RUN: the settle counter runs for ALARM_SETTLE cycles, then mismatch checking is armed.
- i_stop=1, or i_start=0, in any UP_x or RUN -> DOWN. RF permit clears on the transition edge. Remaining enables then clear in reverse order (DR, AN, G2, G1, CA), one every STEP_DELAY cycles. After CA clears -> IDLE. i_start during DOWN is ignored.
- Trips, checked every cycle in all states except IDLE and FAULT:
  - emergency: i_emergency=1, any state.
  - overcurrent: i_i_an_high_n=0 while o_anode_ps_ctrl=1.
  - mismatch: i_not_alarm=0 in RUN after settle.
- On a trip, the next edge enters FAULT: all six enables cleared together (no sequencing), o_fault=1, o_fault_code latched. Simultaneous causes use priority emergency > overcurrent > mismatch. The code is not overwritten while in FAULT.
- FAULT -> IDLE only when i_fault_reset=1 and i_start=0 and i_emergency=0. This clears o_fault and o_fault_code. If i_fault_reset is asserted with i_start=1, it is ignored.
- A trip takes precedence over a stop request in the same cycle.
- Tune delay: the counter increments while i_tune_ok=1 and saturates at TUNE_DELAY. When it reaches TUNE_DELAY, o_not_tune_ok_delayed=0 on the following edge. i_tune_ok=0 zeroes the counter and sets the output to 1 on the next edge. This logic is independent of the sequencer state.
- Counter arithmetic is unsigned CNT_W. It never wraps: the counter resets on every state entry.

Decomposition:
- Package rpsc_pkg:
  - state enum seq_state_t (4-bit).
  - fault code enum fault_code_t (2-bit).
  - index constants for the enable order.
- One sub-module, rpsc_tune_delay: the saturating tune-OK qualifier, parameterised by TUNE_DELAY/CNT_W. The sequencer FSM and the trip logic stay in the top.

Test Plan:
1. Power-up (STEP_DELAY=4, ALARM_SETTLE=2): i_start=1 with healthy returns -> CA at cycle 1, then G1/G2/AN/DR each 4 cycles apart, RF permit and o_running=1 at cycle 21. Enables stay cumulative throughout.
2. Orderly stop: from RUN, pulse i_stop -> RF permit 0 next edge, then DR, AN, G2, G1, CA clear at 4-cycle spacing, IDLE afterwards, o_fault=0.
3. Overcurrent: in UP_AN, drive i_i_an_high_n=0 for 1 cycle -> all enables 0 next edge, o_fault=1, o_fault_code=2. Reset with i_start=1 is ignored; i_start=0 then i_fault_reset=1 returns to IDLE with code 0.
4. Simultaneous trip: in RUN, set i_emergency=1 and i_not_alarm=0 in the same cycle -> o_fault_code=1. A later i_i_an_high_n=0 leaves the code at 1.
5. Mismatch settle: i_not_alarm=0 during the first 2 RUN cycles -> no trip. Held into cycle 3 -> FAULT with o_fault_code=3.
6. Tune delay (TUNE_DELAY=5): i_tune_ok high for 4 cycles then low -> output stays 1. Then high for 6 cycles -> output falls to 0 after the 5th cycle. Dropping i_tune_ok -> output 1 on the next edge. Reset_n=0 mid-sequence -> all outputs return to reset values on that edge.
